// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multi-cycle MIPS control FSM (Moore)
// Define MCPU_BUS_WAIT_EN to stall IF/MRD/MWR until MIO_ready.
module mcpu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Inst_in,
  input  logic        MIO_ready,
  input  logic        zero,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Beq,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        ImmZext,
  output logic        CPU_MIO,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_Control,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MA = 4'd2, S_MRD = 4'd3, S_MWR = 4'd4,
    S_LWB = 4'd5, S_REX = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_JMP = 4'd9,
    S_IEX = 4'd10, S_IWB = 4'd11, S_JAL = 4'd12, S_JR = 4'd13
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                         ALU_XOR = 3'b011, ALU_NOR = 3'b100, ALU_SRL = 3'b101,
                         ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic [5:0] opcode, fun;
  logic       is_jr_fun, bus_wait;
  logic       unused_ok;

  assign opcode    = Inst_in[31:26];
  assign fun       = Inst_in[5:0];
  assign is_jr_fun = (fun == 6'b001000) || (fun == 6'b001001);
  assign state     = state_q;
  // zero is consumed by the datapath's branch gate, not here
  assign unused_ok = ^{zero, MIO_ready, Inst_in[25:6]};

`ifdef MCPU_BUS_WAIT_EN
  assign bus_wait = !MIO_ready;
`else
  assign bus_wait = 1'b0;
`endif

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = bus_wait ? S_IF : S_ID;
      S_ID: begin
        case (opcode)
          6'b100011, 6'b101011: state_d = S_MA;
          6'b000000:            state_d = is_jr_fun ? S_JR : S_REX;
          6'b000100, 6'b000101: state_d = S_BR;
          6'b000010:            state_d = S_JMP;
          6'b000011:            state_d = S_JAL;
          6'b001000, 6'b001100, 6'b001101,
          6'b001110, 6'b001010, 6'b001111: state_d = S_IEX;
          default:              state_d = S_IF;
        endcase
      end
      S_MA:  state_d = (opcode == 6'b100011) ? S_MRD : S_MWR;
      S_MRD: state_d = bus_wait ? S_MRD : S_LWB;
      S_MWR: state_d = bus_wait ? S_MWR : S_IF;
      S_REX: state_d = S_RWB;
      S_IEX: state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; Beq = 1'b0; IorD = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; ALUSrcA = 1'b0;
    RegWrite = 1'b0; ImmZext = 1'b0; CPU_MIO = 1'b0;
    ALUSrcB = 2'b00; RegDst = 2'b00; MemtoReg = 2'b00; PCSource = 2'b00;
    ALU_Control = ALU_AND;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1; CPU_MIO = 1'b1;
        IRWrite = !bus_wait; PCWrite = !bus_wait;
        ALUSrcB = 2'b01; ALU_Control = ALU_ADD;
      end
      S_ID: begin
        ALUSrcB = 2'b11; ALU_Control = ALU_ADD;
      end
      S_MA: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_Control = ALU_ADD;
      end
      S_MRD: begin
        MemRead = 1'b1; IorD = 1'b1; CPU_MIO = 1'b1;
      end
      S_MWR: begin
        MemWrite = !bus_wait; IorD = 1'b1; CPU_MIO = 1'b1;
      end
      S_LWB: begin
        RegWrite = 1'b1; MemtoReg = 2'b01;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        case (fun)
          6'b100010: ALU_Control = ALU_SUB;
          6'b100100: ALU_Control = ALU_AND;
          6'b100101: ALU_Control = ALU_OR;
          6'b100110: ALU_Control = ALU_XOR;
          6'b100111: ALU_Control = ALU_NOR;
          6'b101010: ALU_Control = ALU_SLT;
          6'b000010: ALU_Control = ALU_SRL;
          default:   ALU_Control = ALU_ADD;
        endcase
      end
      S_RWB: begin
        RegWrite = 1'b1; RegDst = 2'b01;
      end
      S_BR: begin
        ALUSrcA = 1'b1; ALU_Control = ALU_SUB; PCSource = 2'b01;
        PCWriteCond = 1'b1; Beq = (opcode == 6'b000100);
      end
      S_JMP: begin
        PCWrite = 1'b1; PCSource = 2'b10;
      end
      S_JAL: begin
        PCWrite = 1'b1; PCSource = 2'b10;
        RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10;
      end
      S_JR: begin
        PCWrite = 1'b1; PCSource = 2'b11;
        if (fun == 6'b001001) begin
          RegWrite = 1'b1; RegDst = 2'b01; MemtoReg = 2'b10;
        end
      end
      S_IEX: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10;
        case (opcode)
          6'b001100: begin ALU_Control = ALU_AND; ImmZext = 1'b1; end
          6'b001101: begin ALU_Control = ALU_OR;  ImmZext = 1'b1; end
          6'b001110: begin ALU_Control = ALU_XOR; ImmZext = 1'b1; end
          6'b001010: ALU_Control = ALU_SLT;
          default:   ALU_Control = ALU_ADD;
        endcase
      end
      S_IWB: begin
        RegWrite = 1'b1;
        MemtoReg = (opcode == 6'b001111) ? 2'b11 : 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb/tb_mcpu_ctrl.sv - self-checking bench for mcpu_ctrl against an instruction-level model
module tb_mcpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Inst_in;
  logic        MIO_ready, zero;
  logic        PCWrite, PCWriteCond, Beq, IorD, MemRead, MemWrite, IRWrite;
  logic        ALUSrcA, RegWrite, ImmZext, CPU_MIO;
  logic [1:0]  ALUSrcB, RegDst, MemtoReg, PCSource;
  logic [2:0]  ALU_Control;
  logic [3:0]  state;

  int checks = 0;
  int fails  = 0;
  int exp_q[$];

  typedef struct packed {
    logic       pcw, pcwc, beq, iord, mrd, mwr, irw, srca, regw, zext, mio;
    logic [1:0] srcb, rdst, m2r, pcsrc;
    logic [2:0] alu;
  } outs_t;

  outs_t obs;

  mcpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Inst_in(Inst_in), .MIO_ready(MIO_ready), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Beq(Beq), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .ImmZext(ImmZext), .CPU_MIO(CPU_MIO), .ALUSrcB(ALUSrcB),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALU_Control(ALU_Control), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = '{pcw: PCWrite, pcwc: PCWriteCond, beq: Beq, iord: IorD, mrd: MemRead,
                 mwr: MemWrite, irw: IRWrite, srca: ALUSrcA, regw: RegWrite,
                 zext: ImmZext, mio: CPU_MIO, srcb: ALUSrcB, rdst: RegDst,
                 m2r: MemtoReg, pcsrc: PCSource, alu: ALU_Control};

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    logic [31:0] r;
    r = $urandom;
    r[31:26] = op;
    r[5:0]   = fn;
    return r;
  endfunction

  // Instruction-level model: the state walk an instruction takes, by class.
  task automatic fill_expected(input logic [31:0] inst);
    logic [5:0] op, fn;
    op = inst[31:26];
    fn = inst[5:0];
    exp_q = '{0, 1};
    case (op)
      6'b100011: exp_q = {exp_q, 2, 3, 5};
      6'b101011: exp_q = {exp_q, 2, 4};
      6'b000000: if (fn == 6'b001000 || fn == 6'b001001) exp_q = {exp_q, 13};
                 else exp_q = {exp_q, 6, 7};
      6'b000100, 6'b000101: exp_q = {exp_q, 8};
      6'b000010: exp_q = {exp_q, 9};
      6'b000011: exp_q = {exp_q, 12};
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001111:
        exp_q = {exp_q, 10, 11};
      default: ;
    endcase
  endtask

  // What each phase of an instruction asks of the datapath.
  function automatic outs_t exp_out(input int st, input logic [31:0] inst);
    outs_t o;
    logic [5:0] op, fn;
    op = inst[31:26];
    fn = inst[5:0];
    o = '0;
    case (st)
      0:  begin o.mrd = 1; o.irw = 1; o.pcw = 1; o.mio = 1; o.srcb = 2'b01; o.alu = 3'b010; end
      1:  begin o.srcb = 2'b11; o.alu = 3'b010; end
      2:  begin o.srca = 1; o.srcb = 2'b10; o.alu = 3'b010; end
      3:  begin o.mrd = 1; o.iord = 1; o.mio = 1; end
      4:  begin o.mwr = 1; o.iord = 1; o.mio = 1; end
      5:  begin o.regw = 1; o.m2r = 2'b01; end
      6: begin
        o.srca = 1;
        o.alu = (fn == 6'b100010) ? 3'b110 : (fn == 6'b100100) ? 3'b000 :
                (fn == 6'b100101) ? 3'b001 : (fn == 6'b100110) ? 3'b011 :
                (fn == 6'b100111) ? 3'b100 : (fn == 6'b101010) ? 3'b111 :
                (fn == 6'b000010) ? 3'b101 : 3'b010;
      end
      7:  begin o.regw = 1; o.rdst = 2'b01; end
      8:  begin o.srca = 1; o.alu = 3'b110; o.pcsrc = 2'b01; o.pcwc = 1; o.beq = (op == 6'b000100); end
      9:  begin o.pcw = 1; o.pcsrc = 2'b10; end
      12: begin o.pcw = 1; o.pcsrc = 2'b10; o.regw = 1; o.rdst = 2'b10; o.m2r = 2'b10; end
      13: begin
        o.pcw = 1; o.pcsrc = 2'b11;
        if (fn == 6'b001001) begin o.regw = 1; o.rdst = 2'b01; o.m2r = 2'b10; end
      end
      10: begin
        o.srca = 1; o.srcb = 2'b10;
        o.alu = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 :
                (op == 6'b001110) ? 3'b011 : (op == 6'b001010) ? 3'b111 : 3'b010;
        o.zext = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
      end
      11: begin o.regw = 1; o.m2r = (op == 6'b001111) ? 2'b11 : 2'b00; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    zero = 1'(($urandom));
`ifndef MCPU_BUS_WAIT_EN
    MIO_ready = 1'(($urandom));
`endif
  endtask

  // Assumes the DUT sits in IF; leaves it in IF of the following instruction.
  task automatic run_instr(input string name, input logic [31:0] inst);
    Inst_in = inst;
    #0;
    fill_expected(inst);
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      checks++;
      if (state !== 4'(exp_q[i])) begin
        fails++;
        $display("FAIL %s state step %0d: got %0d want %0d", name, i, state, exp_q[i]);
      end
      checks++;
      if (obs !== exp_out(exp_q[i], inst)) begin
        fails++;
        $display("FAIL %s outputs step %0d: got %h want %h", name, i, obs, exp_out(exp_q[i], inst));
      end
      tick();
    end
    checks++;
    if (state !== 4'd0) begin
      fails++;
      $display("FAIL %s return to IF: got %0d want 0", name, state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Inst_in = mk(6'b000000, 6'b100000);
    tick(); tick();
    checks++;
    if (state !== 4'd0) begin fails++; $display("FAIL reset state: got %0d want 0", state); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== exp_out(0, Inst_in)) begin
      fails++; $display("FAIL reset IF outputs: got %h want %h", obs, exp_out(0, Inst_in));
    end
  endtask

  task automatic test_directed();
    run_instr("add",  mk(6'b000000, 6'b100000));
    run_instr("sub",  mk(6'b000000, 6'b100010));
    run_instr("srl",  mk(6'b000000, 6'b000010));
    run_instr("lw",   mk(6'b100011, 6'($urandom)));
    run_instr("sw",   mk(6'b101011, 6'($urandom)));
    run_instr("beq",  mk(6'b000100, 6'($urandom)));
    run_instr("bne",  mk(6'b000101, 6'($urandom)));
    run_instr("j",    mk(6'b000010, 6'($urandom)));
    run_instr("jal",  mk(6'b000011, 6'($urandom)));
    run_instr("jr",   mk(6'b000000, 6'b001000));
    run_instr("jalr", mk(6'b000000, 6'b001001));
    run_instr("andi", mk(6'b001100, 6'($urandom)));
    run_instr("slti", mk(6'b001010, 6'($urandom)));
    run_instr("lui",  mk(6'b001111, 6'($urandom)));
    run_instr("unk",  mk(6'b111111, 6'($urandom)));
  endtask

  task automatic test_reset_mid();
    Inst_in = mk(6'b000000, 6'b100000);
    tick(); tick(); tick();
    checks++;
    if (state !== 4'd7 || RegWrite !== 1'b1) begin
      fails++; $display("FAIL reach RWB: got state %0d regw %b want 7 1", state, RegWrite);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      fails++; $display("FAIL reset in RWB: got state %0d regw %b want 0 0", state, RegWrite);
    end
    Inst_in = mk(6'b101011, 6'd0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || MemWrite !== 1'b0) begin
      fails++; $display("FAIL reset in MWR: got state %0d mwr %b want 0 0", state, MemWrite);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[16] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                            6'b000010, 6'b000011, 6'b001000, 6'b001100, 6'b001101, 6'b001110,
                            6'b001010, 6'b001111, 6'b111111, 6'b010001};
    logic [5:0] fns[10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                            6'b100111, 6'b101010, 6'b000010, 6'b001000, 6'b001001};
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
      run_instr("rand", mk(op, fn));
    end
  endtask

`ifdef MCPU_BUS_WAIT_EN
  task automatic test_bus_wait();
    Inst_in = mk(6'b100011, 6'd0);
    MIO_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || PCWrite !== 1'b0 || IRWrite !== 1'b0 || MemRead !== 1'b1) begin
      fails++; $display("FAIL IF wait: got st %0d pcw %b irw %b want 0 0 0", state, PCWrite, IRWrite);
    end
    tick();
    checks++;
    if (state !== 4'd0) begin fails++; $display("FAIL IF hold: got %0d want 0", state); end
    MIO_ready = 1'b1;
    tick(); tick(); tick();
    MIO_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1 || CPU_MIO !== 1'b1) begin
        fails++; $display("FAIL MRD wait %0d: got st %0d want 3", i, state);
      end
      tick();
    end
    MIO_ready = 1'b1;
    tick();
    checks++;
    if (state !== 4'd5) begin fails++; $display("FAIL MRD release: got %0d want 5", state); end
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    Inst_in = '0;
    MIO_ready = 1'b1;
    zero = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
`ifdef MCPU_BUS_WAIT_EN
    test_bus_wait();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mcpu_ctrl.md
MCPU_CTRL -- requirements
Module: mcpu_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have port Inst_in, input, 32 bits: instruction register contents; OPcode=[31:26], Fun=[5:0].
REQ-004 The block SHALL have ports MIO_ready (input, 1: memory/IO access complete) and zero (input, 1: ALU result zero).
REQ-005 The block SHALL have outputs PCWrite, PCWriteCond, Beq, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, ImmZext and CPU_MIO, each 1 bit, each a datapath strobe/select.
REQ-006 The block SHALL have outputs ALUSrcB, RegDst, MemtoReg and PCSource, each 2 bits; ALU_Control, 3 bits; state, 4 bits for debug.

Function
REQ-007 The block SHALL be a Moore FSM; all outputs SHALL be decoded from state plus Inst_in and SHALL default to 0 in every state unless listed.
REQ-008 The state encoding SHALL be IF=0, ID=1, MA=2, MRD=3, MWR=4, LWB=5, REX=6, RWB=7, BR=8, JMP=9, IEX=10, IWB=11, JAL=12, JR=13.
REQ-009 ALU_Control SHALL be encoded and=000, or=001, add=010, xor=011, nor=100, srl=101, sub=110, slt=111.
REQ-010 IF SHALL assert MemRead, IRWrite, PCWrite and CPU_MIO, with ALUSrcB=01, ALU add, and IF->ID.
REQ-011 ID SHALL drive ALUSrcB=11 with ALU add (branch target to ALUOut) and dispatch on OPcode:
- lw(100011)/sw(101011)->MA
- R-type(000000)->REX, except Fun 001000 (jr) or 001001 (jalr)->JR
- beq(000100)/bne(000101)->BR
- j(000010)->JMP; jal(000011)->JAL
- addi/andi/ori/xori/slti/lui(001000/001100/001101/001110/001010/001111)->IEX
- any other opcode->IF (executed as nop).
REQ-012 MA SHALL drive ALUSrcA=1, ALUSrcB=10, ALU add; lw->MRD, sw->MWR.
REQ-013 MRD SHALL assert MemRead, IorD and CPU_MIO and go ->LWB; LWB SHALL assert RegWrite with RegDst=00 and MemtoReg=01, then ->IF.
REQ-014 MWR SHALL assert MemWrite, IorD and CPU_MIO, then ->IF.
REQ-015 REX SHALL drive ALUSrcA=1, ALUSrcB=00 and ALU from Fun: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl, other->add; then ->RWB.
REQ-016 RWB SHALL assert RegWrite with RegDst=01 and MemtoReg=00, then ->IF.
REQ-017 BR SHALL drive ALUSrcA=1, ALUSrcB=00, ALU sub, PCSource=01 and PCWriteCond=1, with Beq=1 for beq and 0 for bne; the datapath applies zero/!zero. BR->IF.
REQ-018 JMP SHALL assert PCWrite with PCSource=10 and go ->IF; JAL SHALL do the same and additionally assert RegWrite with RegDst=10 ($31) and MemtoReg=10 (PC+4), then ->IF.
REQ-019 JR SHALL assert PCWrite with PCSource=11; for jalr it SHALL also assert RegWrite with RegDst=01 and MemtoReg=10. JR->IF.
REQ-020 IEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALU add/and/or/xor/slt for addi/andi/ori/xori/slti, and ImmZext=1 for andi/ori/xori; IEX->IWB.
REQ-021 IWB SHALL assert RegWrite with RegDst=00, MemtoReg=11 for lui and 00 otherwise, then ->IF.
REQ-022 Latencies SHALL be: lw 5 cycles; sw, R-type and I-type 4 cycles; branch, j, jal, jr and jalr 3 cycles (without wait states).

Reset
REQ-023 While rst_n=0 at a clock edge, the state SHALL become IF and the state output SHALL read 0.
REQ-024 Reset asserted mid-instruction (any state, including a wait) SHALL abort the instruction, with no further RegWrite/MemWrite after the edge.
REQ-025 After reset the first cycle SHALL be IF, with IF outputs per REQ-010.

Configuration
REQ-026 Macro MCPU_BUS_WAIT_EN defined: in IF, MRD and MWR, while MIO_ready=0 the state SHALL hold and PCWrite, IRWrite and MemWrite SHALL be forced to 0, with MemRead/CPU_MIO/IorD held; the state SHALL advance on the first cycle MIO_ready=1.
REQ-027 Macro MCPU_BUS_WAIT_EN undefined: MIO_ready SHALL be ignored and every state SHALL take exactly one cycle.

Verification
REQ-028 Reset, then Inst_in=add (op 000000, Fun 100000) -> state 0,1,6,7,0; RWB: RegWrite=1, RegDst=01; REX: ALU_Control=010.
REQ-029 lw (100011) -> states 0,1,2,3,5,0; MRD: IorD=1, MemRead=1; LWB: MemtoReg=01. sw (101011) -> 0,1,2,4,0 with MemWrite=1 only in state 4.
REQ-030 bne (000101) -> BR: PCWriteCond=1, Beq=0, ALU_Control=110, PCSource=01; jal (000011) -> JAL: PCWrite=1, RegDst=10, MemtoReg=10.
REQ-031 With MCPU_BUS_WAIT_EN defined, lw with MIO_ready=0 for 3 cycles in MRD -> state stays 3 for 3 cycles, then advances to 5 on MIO_ready=1; IF with MIO_ready=0 -> PCWrite=0, IRWrite=0.
REQ-032 rst_n=0 during RWB -> next state 0 and RegWrite=0. Unknown opcode 111111 -> states 0,1,0.
